// File: rtl/hamming_secded_pipe_checker.sv
// hamming_secded_pipe_checker
//   SEC-DED Hamming checker/corrector for the SSD-RAID read and
//   read-for-write paths. It accepts one codeword per beat, computes the
//   syndrome and the overall parity, corrects single-bit errors when
//   correct_en is set, and flags double-bit errors. Tag and op fields
//   pass through unchanged. There are two register stages with
//   valid/ready backpressure, and two saturating error counters.
//
//   Codeword layout: bit i is Hamming position i+1 for i < CW-1. Parity
//   bits sit at power-of-two positions, and data bits fill the remaining
//   positions in ascending order. Bit CW-1 is the overall parity bit.
//
// Ports
//   clk, reset_n           clock; asynchronous active-low reset
//   in_valid/in_ready      input handshake
//   in_cw, in_tag, in_op   received codeword, address tag, read-for-write flag
//   correct_en             1 = correct single errors, 0 = detect only (sampled with the beat)
//   out_valid/out_ready    output handshake
//   out_cw, out_data       resulting codeword and the data bits extracted from it
//   out_synd, out_status   raw syndrome; 00 clean, 01 corrected, 10 uncorrectable, 11 detected only
//   out_tag, out_op        sideband carried with the beat
//   cnt_corr, cnt_uncorr   saturating counts of delivered status-01 / status-10 beats
//   cnt_clr                synchronous clear of both counters (wins over a same-cycle count)

module hamming_secded_pipe_checker #(
  parameter  int DATA_W = 8,
  parameter  int TAG_W  = 8,
  parameter  int CNT_W  = 16,
  // smallest p with 2**p >= DATA_W + p + 1
  localparam int P_W    = (DATA_W <= 1)   ? 2 :
                          (DATA_W <= 4)   ? 3 :
                          (DATA_W <= 11)  ? 4 :
                          (DATA_W <= 26)  ? 5 :
                          (DATA_W <= 57)  ? 6 :
                          (DATA_W <= 120) ? 7 : 8,
  localparam int CW     = DATA_W + P_W + 1
) (
  input  logic              clk,
  input  logic              reset_n,

  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CW-1:0]     in_cw,
  input  logic [TAG_W-1:0]  in_tag,
  input  logic              in_op,
  input  logic              correct_en,

  output logic              out_valid,
  input  logic              out_ready,
  output logic [CW-1:0]     out_cw,
  output logic [DATA_W-1:0] out_data,
  output logic [P_W-1:0]    out_synd,
  output logic [1:0]        out_status,
  output logic [TAG_W-1:0]  out_tag,
  output logic              out_op,

  output logic [CNT_W-1:0]  cnt_corr,
  output logic [CNT_W-1:0]  cnt_uncorr,
  input  logic              cnt_clr
);

  localparam logic [1:0] ST_CLEAN  = 2'b00;
  localparam logic [1:0] ST_CORR   = 2'b01;
  localparam logic [1:0] ST_UNCORR = 2'b10;
  localparam logic [1:0] ST_DET    = 2'b11;

  // Syndrome bit j is the XOR of every Hamming position (1..CW-1) whose
  // index has bit j set. The overall parity bit is not part of it.
  function automatic logic [P_W-1:0] calc_synd(input logic [CW-1:0] cw);
    logic [P_W-1:0] s;
    s = '0;
    for (int i = 0; i < CW - 1; i++) begin
      for (int j = 0; j < P_W; j++) begin
        if ((((i + 1) >> j) & 1) != 0) begin
          s[j] = s[j] ^ cw[i];
        end
      end
    end
    return s;
  endfunction

  // Data bits live at the non-power-of-two positions, lowest position first.
  function automatic logic [DATA_W-1:0] extract_data(input logic [CW-1:0] cw);
    logic [DATA_W-1:0] d;
    int k;
    d = '0;
    k = 0;
    for (int i = 0; i < CW - 1; i++) begin
      if (((i + 1) & i) != 0) begin
        if (k < DATA_W) begin
          d[k] = cw[i];
        end
        k++;
      end
    end
    return d;
  endfunction

  // Both stages move together. A full output register that is not being
  // taken freezes the whole pipe, so the input is stalled as well.
  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  logic [P_W-1:0] in_synd;
  logic           in_chk;
  assign in_synd = calc_synd(in_cw);
  assign in_chk  = ^in_cw;

  // Stage 1: syndrome, overall check and the beat's sideband.
  logic              s1_valid;
  logic [P_W-1:0]    s1_synd;
  logic              s1_chk;
  logic [CW-1:0]     s1_cw;
  logic [TAG_W-1:0]  s1_tag;
  logic              s1_op;
  logic              s1_cen;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_synd  <= '0;
      s1_chk   <= 1'b0;
      s1_cw    <= '0;
      s1_tag   <= '0;
      s1_op    <= 1'b0;
      s1_cen   <= 1'b0;
    end else if (adv) begin
      // in_ready equals adv, so in_valid here is exactly "beat accepted";
      // otherwise a bubble is loaded.
      s1_valid <= in_valid;
      s1_synd  <= in_synd;
      s1_chk   <= in_chk;
      s1_cw    <= in_cw;
      s1_tag   <= in_tag;
      s1_op    <= in_op;
      s1_cen   <= correct_en;
    end
  end

  // Classification and correction for the beat held in stage 1.
  int             flip_pos;
  logic [CW-1:0]  flip_mask;
  logic [CW-1:0]  fix_cw;
  logic [1:0]     fix_status;

  always_comb begin
    // syndrome 0 with odd overall parity means the parity bit itself flipped
    flip_pos = (s1_synd == '0) ? (CW - 1) : (int'(s1_synd) - 1);
    flip_mask = '0;
    for (int i = 0; i < CW; i++) begin
      flip_mask[i] = (i == flip_pos);
    end

    fix_cw     = s1_cw;
    fix_status = ST_CLEAN;
    if (s1_chk) begin
      if (int'(s1_synd) > CW - 1) begin
        // odd error count pointing outside the codeword: at least three flips
        fix_status = ST_UNCORR;
      end else if (s1_cen) begin
        fix_cw     = s1_cw ^ flip_mask;
        fix_status = ST_CORR;
      end else begin
        fix_status = ST_DET;
      end
    end else if (s1_synd != '0) begin
      // even parity with a nonzero syndrome: double error
      fix_status = ST_UNCORR;
    end
  end

  // Stage 2: registered results.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid  <= 1'b0;
      out_cw     <= '0;
      out_data   <= '0;
      out_synd   <= '0;
      out_status <= ST_CLEAN;
      out_tag    <= '0;
      out_op     <= 1'b0;
    end else if (adv) begin
      out_valid  <= s1_valid;
      out_cw     <= fix_cw;
      out_data   <= extract_data(fix_cw);
      out_synd   <= s1_synd;
      out_status <= fix_status;
      out_tag    <= s1_tag;
      out_op     <= s1_op;
    end
  end

  // Counters advance on a delivered beat only and stick at all-ones.
  logic out_hs;
  assign out_hs = out_valid && out_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_corr   <= '0;
      cnt_uncorr <= '0;
    end else if (cnt_clr) begin
      cnt_corr   <= '0;
      cnt_uncorr <= '0;
    end else if (out_hs) begin
      if (out_status == ST_CORR && cnt_corr != '1) begin
        cnt_corr <= cnt_corr + 1'b1;
      end
      if (out_status == ST_UNCORR && cnt_uncorr != '1) begin
        cnt_uncorr <= cnt_uncorr + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hamming_secded_pipe_checker.sv
// Directed bench for hamming_secded_pipe_checker with DATA_W=8.
// Reference codeword: data 0xA5 encodes to 0x0A27.

module tb_hamming_secded_pipe_checker;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [12:0] in_cw;
  logic [7:0]  in_tag;
  logic        in_op;
  logic        correct_en;
  logic        out_valid;
  logic        out_ready;
  logic [12:0] out_cw;
  logic [7:0]  out_data;
  logic [3:0]  out_synd;
  logic [1:0]  out_status;
  logic [7:0]  out_tag;
  logic        out_op;
  logic [15:0] cnt_corr;
  logic [15:0] cnt_uncorr;
  logic        cnt_clr;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] exp_corr   = '0;
  logic [15:0] exp_uncorr = '0;

  always #5 clk = ~clk;

  hamming_secded_pipe_checker dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_cw      (in_cw),
    .in_tag     (in_tag),
    .in_op      (in_op),
    .correct_en (correct_en),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_cw     (out_cw),
    .out_data   (out_data),
    .out_synd   (out_synd),
    .out_status (out_status),
    .out_tag    (out_tag),
    .out_op     (out_op),
    .cnt_corr   (cnt_corr),
    .cnt_uncorr (cnt_uncorr),
    .cnt_clr    (cnt_clr)
  );

  // Drive one beat with out_ready high. Returns at the negedge where the
  // beat sits in the output register; the next posedge hands it off.
  // correct_en is dropped right after acceptance so a stage that reads it
  // late sees the wrong value.
  task automatic send_one(input logic [12:0] cw, input logic [7:0] tag,
                          input logic op, input logic cen);
    @(negedge clk);
    out_ready  = 1'b1;
    in_valid   = 1'b1;
    in_cw      = cw;
    in_tag     = tag;
    in_op      = op;
    correct_en = cen;
    @(posedge clk);
    #1;
    in_valid   = 1'b0;
    in_cw      = '0;
    in_tag     = '0;
    in_op      = 1'b0;
    correct_en = ~cen;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic retire();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; in_valid = 1'b0; in_cw = '0; in_tag = '0; in_op = 1'b0;
    correct_en = 1'b0; out_ready = 1'b1; cnt_clr = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({out_valid, out_status, out_cw, out_tag} !== 24'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got valid=%b status=%b cw=%h tag=%h, want all zero",
               out_valid, out_status, out_cw, out_tag);
    end
    n_checks++;
    if ({cnt_corr, cnt_uncorr} !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_counters: got %h/%h, want 0/0", cnt_corr, cnt_uncorr);
    end
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b, want 1", in_ready);
    end
  endtask

  task automatic test_clean();
    @(negedge clk);
    in_valid = 1'b1; in_cw = 13'h0A27; in_tag = 8'h3C; in_op = 1'b1; correct_en = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL clean_latency_early: out_valid got %b one edge after accept, want 0", out_valid);
    end
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL clean_latency: out_valid got %b, want 1", out_valid);
    end
    n_checks++;
    if ({out_status, out_synd, out_data} !== {2'b00, 4'd0, 8'hA5}) begin
      n_fail++;
      $display("FAIL clean_result: got status=%b synd=%0d data=%h, want 00/0/a5",
               out_status, out_synd, out_data);
    end
    n_checks++;
    if ({out_cw, out_tag, out_op} !== {13'h0A27, 8'h3C, 1'b1}) begin
      n_fail++;
      $display("FAIL clean_passthru: got cw=%h tag=%h op=%b, want 0a27/3c/1", out_cw, out_tag, out_op);
    end
    retire();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL clean_no_dup: out_valid got %b after handoff, want 0", out_valid);
    end
  endtask

  task automatic test_single();
    // data bit 2 (position 6) flipped
    send_one(13'h0A07, 8'h21, 1'b0, 1'b1);
    n_checks++;
    if ({out_synd, out_status, out_cw, out_data} !== {4'd6, 2'b01, 13'h0A27, 8'hA5}) begin
      n_fail++;
      $display("FAIL single_pos6: got synd=%0d status=%b cw=%h data=%h, want 6/01/0a27/a5",
               out_synd, out_status, out_cw, out_data);
    end
    retire();
    exp_corr++;
    n_checks++;
    if (cnt_corr !== exp_corr) begin
      n_fail++;
      $display("FAIL single_cnt1: cnt_corr got %0d, want %0d", cnt_corr, exp_corr);
    end
    // overall parity bit flipped
    send_one(13'h1A27, 8'h22, 1'b1, 1'b1);
    n_checks++;
    if ({out_synd, out_status, out_cw, out_op} !== {4'd0, 2'b01, 13'h0A27, 1'b1}) begin
      n_fail++;
      $display("FAIL single_parity_bit: got synd=%0d status=%b cw=%h op=%b, want 0/01/0a27/1",
               out_synd, out_status, out_cw, out_op);
    end
    retire();
    exp_corr++;
    // highest Hamming position (12) flipped
    send_one(13'h0227, 8'h23, 1'b0, 1'b1);
    n_checks++;
    if ({out_synd, out_status, out_cw, out_data} !== {4'd12, 2'b01, 13'h0A27, 8'hA5}) begin
      n_fail++;
      $display("FAIL single_pos12: got synd=%0d status=%b cw=%h data=%h, want 12/01/0a27/a5",
               out_synd, out_status, out_cw, out_data);
    end
    retire();
    exp_corr++;
    n_checks++;
    if ({cnt_corr, cnt_uncorr} !== {exp_corr, exp_uncorr}) begin
      n_fail++;
      $display("FAIL single_cnt: got %0d/%0d, want %0d/%0d", cnt_corr, cnt_uncorr, exp_corr, exp_uncorr);
    end
  endtask

  task automatic test_double();
    // positions 1 and 2 flipped
    send_one(13'h0A24, 8'h31, 1'b0, 1'b1);
    n_checks++;
    if ({out_synd, out_status, out_cw} !== {4'd3, 2'b10, 13'h0A24}) begin
      n_fail++;
      $display("FAIL double_err: got synd=%0d status=%b cw=%h, want 3/10/0a24", out_synd, out_status, out_cw);
    end
    retire();
    exp_uncorr++;
    n_checks++;
    if (cnt_uncorr !== exp_uncorr) begin
      n_fail++;
      $display("FAIL double_cnt: cnt_uncorr got %0d, want %0d", cnt_uncorr, exp_uncorr);
    end
    // positions 1, 4, 8 flipped: odd parity, syndrome 13 is past the codeword
    send_one(13'h0AAE, 8'h32, 1'b0, 1'b1);
    n_checks++;
    if ({out_synd, out_status, out_cw} !== {4'd13, 2'b10, 13'h0AAE}) begin
      n_fail++;
      $display("FAIL synd_oob: got synd=%0d status=%b cw=%h, want 13/10/0aae", out_synd, out_status, out_cw);
    end
    retire();
    exp_uncorr++;
    // detect-only mode
    send_one(13'h0A07, 8'h33, 1'b0, 1'b0);
    n_checks++;
    if ({out_synd, out_status, out_cw, out_data} !== {4'd6, 2'b11, 13'h0A07, 8'hA1}) begin
      n_fail++;
      $display("FAIL detect_only: got synd=%0d status=%b cw=%h data=%h, want 6/11/0a07/a1",
               out_synd, out_status, out_cw, out_data);
    end
    retire();
    n_checks++;
    if ({cnt_corr, cnt_uncorr} !== {exp_corr, exp_uncorr}) begin
      n_fail++;
      $display("FAIL double_cnt_final: got %0d/%0d, want %0d/%0d",
               cnt_corr, cnt_uncorr, exp_corr, exp_uncorr);
    end
  endtask

  task automatic test_back_to_back();
    logic [12:0] bb_cw  [4];
    logic [7:0]  bb_tag [4];
    logic [12:0] bb_ecw [4];
    logic [1:0]  bb_est [4];
    int sent, rcvd;
    logic acc;
    bb_cw  = '{13'h0A27, 13'h0A07, 13'h0A24, 13'h1A27};
    bb_tag = '{8'h41, 8'h42, 8'h43, 8'h44};
    bb_ecw = '{13'h0A27, 13'h0A27, 13'h0A24, 13'h0A27};
    bb_est = '{2'b00, 2'b01, 2'b10, 2'b01};
    sent = 0;
    rcvd = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(negedge clk);
      out_ready  = !(cyc >= 2 && cyc <= 4);
      correct_en = 1'b1;
      in_valid   = (sent < 4);
      if (sent < 4) begin
        in_cw  = bb_cw[sent];
        in_tag = bb_tag[sent];
        in_op  = sent[0];
      end
      #1;
      if (cyc >= 2 && cyc <= 4) begin
        n_checks++;
        if (in_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL stall_in_ready: cycle %0d got %b, want 0", cyc, in_ready);
        end
        n_checks++;
        if ({out_valid, out_tag, out_cw, out_status} !== {1'b1, bb_tag[0], bb_ecw[0], bb_est[0]}) begin
          n_fail++;
          $display("FAIL stall_hold: cycle %0d got valid=%b tag=%h cw=%h status=%b, want 1/%h/%h/%b",
                   cyc, out_valid, out_tag, out_cw, out_status, bb_tag[0], bb_ecw[0], bb_est[0]);
        end
      end
      if (out_valid && out_ready) begin
        n_checks++;
        if (rcvd >= 4) begin
          n_fail++;
          $display("FAIL burst_extra: unexpected beat tag=%h after %0d delivered, want none", out_tag, rcvd);
        end else if ({out_tag, out_cw, out_status, out_op} !==
                     {bb_tag[rcvd], bb_ecw[rcvd], bb_est[rcvd], rcvd[0]}) begin
          n_fail++;
          $display("FAIL burst_order: beat %0d got tag=%h cw=%h status=%b op=%b, want %h/%h/%b/%b",
                   rcvd, out_tag, out_cw, out_status, out_op, bb_tag[rcvd], bb_ecw[rcvd], bb_est[rcvd], rcvd[0]);
        end
        rcvd++;
      end
      acc = in_valid && in_ready;
      @(posedge clk);
      if (acc) sent++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    n_checks++;
    if (sent != 4 || rcvd != 4) begin
      n_fail++;
      $display("FAIL burst_count: sent=%0d delivered=%0d, want 4/4", sent, rcvd);
    end
    exp_corr   = exp_corr + 16'd2;
    exp_uncorr = exp_uncorr + 16'd1;
    n_checks++;
    if ({cnt_corr, cnt_uncorr} !== {exp_corr, exp_uncorr}) begin
      n_fail++;
      $display("FAIL burst_cnt: got %0d/%0d, want %0d/%0d", cnt_corr, cnt_uncorr, exp_corr, exp_uncorr);
    end
  endtask

  task automatic test_saturate();
    @(negedge clk);
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    n_checks++;
    if ({cnt_corr, cnt_uncorr} !== 32'h0) begin
      n_fail++;
      $display("FAIL clr_idle: got %0d/%0d, want 0/0", cnt_corr, cnt_uncorr);
    end
    send_one(13'h0A24, 8'h51, 1'b0, 1'b1);
    retire();
    // 65537 corrected beats streamed back to back
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; in_cw = 13'h0A07; in_tag = 8'h52; correct_en = 1'b1;
    repeat (65537) @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({cnt_corr, cnt_uncorr} !== {16'hFFFF, 16'd1}) begin
      n_fail++;
      $display("FAIL saturate: got %h/%h, want ffff/0001", cnt_corr, cnt_uncorr);
    end
    // clear in the same cycle as a counted handshake
    send_one(13'h0A07, 8'h53, 1'b0, 1'b1);
    cnt_clr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cnt_clr = 1'b0;
    n_checks++;
    if ({cnt_corr, cnt_uncorr} !== 32'h0) begin
      n_fail++;
      $display("FAIL clr_priority: got %h/%h, want 0/0", cnt_corr, cnt_uncorr);
    end
    send_one(13'h0A07, 8'h54, 1'b0, 1'b1);
    retire();
    n_checks++;
    if (cnt_corr !== 16'd1) begin
      n_fail++;
      $display("FAIL count_after_clr: got %0d, want 1", cnt_corr);
    end
  endtask

  task automatic test_reset_in_flight();
    int stale;
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_cw = 13'h0A07; in_tag = 8'h61; correct_en = 1'b1;
    @(posedge clk);
    #1;
    in_tag = 8'h62;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({out_valid, out_tag} !== {1'b1, 8'h61}) begin
      n_fail++;
      $display("FAIL flight_setup: got valid=%b tag=%h, want 1/61", out_valid, out_tag);
    end
    #2;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({out_valid, out_cw, out_tag, out_status} !== 24'h0) begin
      n_fail++;
      $display("FAIL async_reset_out: got valid=%b cw=%h tag=%h status=%b, want all zero",
               out_valid, out_cw, out_tag, out_status);
    end
    n_checks++;
    if ({cnt_corr, cnt_uncorr} !== 32'h0) begin
      n_fail++;
      $display("FAIL async_reset_cnt: got %0d/%0d, want 0/0", cnt_corr, cnt_uncorr);
    end
    @(negedge clk);
    reset_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL post_reset_ready: got %b, want 1", in_ready);
    end
    stale = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    n_checks++;
    if (stale != 0) begin
      n_fail++;
      $display("FAIL stale_beat: out_valid seen %0d times after reset, want 0", stale);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_clean();
    test_single();
    test_double();
    test_back_to_back();
    test_saturate();
    test_reset_in_flight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
